// File: rtl/phase_sequencer.sv
// Purpose : walks a one-hot phase through FETCH..WRITEBACK and gates each stage's output buffer.
// Latency : phase is registered (one edge per step); stage_en/retire/busy are combinational from phase and inputs.
// Backpress: stall_req holds the current phase with all stage enables low; flush aborts to FETCH (or HALT).
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   run                   level; 1 = keep issuing instructions, 0 = halt at the next instruction boundary
//   stall_req             level; hold the current phase
//   flush                 one-cycle pulse; abandon the instruction in flight and restart
//   phase                 one-hot current phase, all-zero = HALT (bit 0 FETCH, MSB WRITEBACK)
//   stage_en              per-stage buffer enable for the completing cycle of each phase
//   retire                instruction completed this cycle
//   busy                  an instruction is in flight
//   retire_cnt, stall_cnt performance counters, built only when PHASE_PERF_CNT_EN is defined
//
// Optional feature: define PHASE_PERF_CNT_EN to build the retire/stall counters; otherwise both read 0.

module phase_sequencer #(
  parameter int NUM_PHASE = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 stall_req,
  input  logic                 flush,
  output logic [NUM_PHASE-1:0] phase,
  output logic [NUM_PHASE-1:0] stage_en,
  output logic                 retire,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] retire_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [NUM_PHASE-1:0] PH_FETCH = {{(NUM_PHASE-1){1'b0}}, 1'b1};
  localparam logic [NUM_PHASE-1:0] PH_HALT  = '0;

  // Classification of the phase register: legal idle, legal active, or
  // anything that is neither zero nor one-hot (e.g. after an upset).
  typedef enum logic [1:0] {
    CLS_HALT    = 2'd0,
    CLS_ACTIVE  = 2'd1,
    CLS_CORRUPT = 2'd2
  } phase_cls_t;

  phase_cls_t           phase_cls;
  logic [NUM_PHASE-1:0] phase_q;
  logic [NUM_PHASE-1:0] phase_nxt;
  logic                 is_last;
  logic                 one_hot;
  logic                 advance;

  // x & (x-1) clears the lowest set bit; zero result on a non-zero x means one-hot.
  assign one_hot = ((phase_q & (phase_q - PH_FETCH)) == '0);
  assign is_last = phase_q[NUM_PHASE-1];

  always_comb begin
    phase_cls = CLS_CORRUPT;
    if (phase_q == PH_HALT) begin
      phase_cls = CLS_HALT;
    end else if (one_hot) begin
      phase_cls = CLS_ACTIVE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_HALT;
    end else begin
      phase_q <= phase_nxt;
    end
  end

  // Next-state logic. run is only consulted at instruction boundaries:
  // from HALT, on WRITEBACK completion and on flush.
  always_comb begin
    phase_nxt = PH_HALT;
    case (phase_cls)
      CLS_HALT: begin
        // stall_req and flush have no meaning without an instruction in flight.
        phase_nxt = run ? PH_FETCH : PH_HALT;
      end
      CLS_ACTIVE: begin
        if (flush) begin
          phase_nxt = run ? PH_FETCH : PH_HALT;
        end else if (stall_req) begin
          phase_nxt = phase_q;
        end else if (is_last) begin
          phase_nxt = run ? PH_FETCH : PH_HALT;
        end else begin
          phase_nxt = phase_q << 1;
        end
      end
      default: begin
        // Illegal encoding: drop to HALT and let run restart cleanly.
        phase_nxt = PH_HALT;
      end
    endcase
  end

  // A phase completes only on a cycle that is neither stalled nor flushed.
  assign advance  = ~stall_req & ~flush;
  assign phase    = phase_q;
  assign stage_en = phase_q & {NUM_PHASE{advance}};
  assign retire   = is_last & advance;
  assign busy     = |phase_q;

`ifdef PHASE_PERF_CNT_EN
  // Counters wrap naturally at 2^CNT_WIDTH; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // A flush cycle is an abort, not a stall, even if stall_req is also high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (busy & stall_req & ~flush) begin
      stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end
`else
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NUM_PHASE=5, CNT_WIDTH=4).
// A stage-index model (-1 = HALT, 0..4 = phase number) predicts every output
// and is compared on each falling edge; directed steps also carry literal
// expectations for phase and retire that pin the model.

module tb_phase_sequencer;

  localparam int NP = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          stall_req = 1'b0;
  logic          flush = 1'b0;
  logic [NP-1:0] phase;
  logic [NP-1:0] stage_en;
  logic          retire;
  logic          busy;
  logic [CW-1:0] retire_cnt;
  logic [CW-1:0] stall_cnt;

  phase_sequencer #(.NUM_PHASE(NP), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .stall_req  (stall_req),
    .flush      (flush),
    .phase      (phase),
    .stage_en   (stage_en),
    .retire     (retire),
    .busy       (busy),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_stage;   // -1 = HALT, otherwise index of the current phase
  int m_ret;
  int m_stl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= -1;
      m_ret   <= 0;
      m_stl   <= 0;
    end else begin
      if (m_stage < 0) begin
        m_stage <= run ? 0 : -1;
      end else if (flush) begin
        m_stage <= run ? 0 : -1;
      end else if (stall_req) begin
        m_stage <= m_stage;
        m_stl   <= (m_stl + 1) % (1 << CW);
      end else if (m_stage == NP - 1) begin
        m_stage <= run ? 0 : -1;
        m_ret   <= (m_ret + 1) % (1 << CW);
      end else begin
        m_stage <= m_stage + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NP-1:0] e_ph;
      logic          e_active;
      logic          e_done;
      logic [CW-1:0] e_rc;
      logic [CW-1:0] e_sc;
      e_ph     = (m_stage < 0) ? '0 : NP'(1 << m_stage);
      e_active = !stall_req && !flush;
      e_done   = (m_stage == NP - 1) && e_active;
`ifdef PHASE_PERF_CNT_EN
      e_rc = CW'(m_ret);
      e_sc = CW'(m_stl);
`else
      e_rc = '0;
      e_sc = '0;
`endif
      check("m_phase", 32'(phase), 32'(e_ph));
      check("m_stage_en", 32'(stage_en), e_active ? 32'(e_ph) : 32'd0);
      check("m_retire", 32'(retire), 32'(e_done));
      check("m_busy", 32'(busy), 32'(m_stage >= 0));
      check("m_retire_cnt", 32'(retire_cnt), 32'(e_rc));
      check("m_stall_cnt", 32'(stall_cnt), 32'(e_sc));
    end
  end

  // One cycle: drive inputs just after a rising edge, check the phase held in
  // that cycle on the falling edge, then return just after the next rising edge.
  task automatic cyc(input logic s, input logic f, input logic r,
                     input logic [NP-1:0] exp_ph, input logic exp_ret, input string nm);
    stall_req = s;
    flush     = f;
    run       = r;
    @(negedge clk);
    check({nm, "_phase"}, 32'(phase), 32'(exp_ph));
    check({nm, "_retire"}, 32'(retire), 32'(exp_ret));
    @(posedge clk);
    #1;
  endtask

  logic [CW-1:0] exp_wrap;

  initial begin
    // Reset held from time 0.
    #2;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_stage_en", 32'(stage_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Free-running walk: HALT, then two full instructions.
    cyc(0, 0, 1, 5'b00000, 0, "halt_to_fetch");
    for (int i = 0; i < 10; i++) begin
      logic [NP-1:0] ph;
      ph = NP'(1 << (i % NP));
      cyc(0, 0, 1, ph, (i % NP) == NP - 1, "walk");
    end

    // Three stall cycles in EXECUTE: instruction spans 8 cycles.
    cyc(0, 0, 1, 5'b00001, 0, "stall_f");
    cyc(0, 0, 1, 5'b00010, 0, "stall_d");
    cyc(1, 0, 1, 5'b00100, 0, "stall_e0");
    cyc(1, 0, 1, 5'b00100, 0, "stall_e1");
    cyc(1, 0, 1, 5'b00100, 0, "stall_e2");
    cyc(0, 0, 1, 5'b00100, 0, "stall_e3");
    cyc(0, 0, 1, 5'b01000, 0, "stall_m");
    cyc(0, 0, 1, 5'b10000, 1, "stall_w");
`ifdef PHASE_PERF_CNT_EN
    check("stall_cnt_three", 32'(stall_cnt), 32'd3);
`else
    check("stall_cnt_off", 32'(stall_cnt), 32'd0);
`endif

    // Flush in MEMORY restarts at FETCH without retiring.
    cyc(0, 0, 1, 5'b00001, 0, "fl_f");
    cyc(0, 0, 1, 5'b00010, 0, "fl_d");
    cyc(0, 0, 1, 5'b00100, 0, "fl_e");
    cyc(0, 1, 1, 5'b01000, 0, "fl_m");
    cyc(0, 0, 1, 5'b00001, 0, "fl_restart");
    // Flush and stall together in DECODE: flush wins.
    cyc(1, 1, 1, 5'b00010, 0, "flst_d");
    cyc(0, 0, 1, 5'b00001, 0, "flst_restart");

    // run dropped in DECODE: instruction still completes, then HALT.
    cyc(0, 0, 0, 5'b00010, 0, "rd_d");
    cyc(0, 0, 0, 5'b00100, 0, "rd_e");
    cyc(0, 0, 0, 5'b01000, 0, "rd_m");
    cyc(0, 0, 0, 5'b10000, 1, "rd_w");
    cyc(0, 0, 0, 5'b00000, 0, "rd_halt0");
    cyc(1, 1, 0, 5'b00000, 0, "rd_halt_ignore");
    cyc(1, 1, 1, 5'b00000, 0, "rd_halt_run");
    cyc(0, 0, 1, 5'b00001, 0, "rd_fetch");

    // Flush with run low goes to HALT.
    cyc(0, 0, 1, 5'b00010, 0, "flh_d");
    cyc(0, 1, 0, 5'b00100, 0, "flh_e");
    cyc(0, 0, 0, 5'b00000, 0, "flh_halt");

    // Asynchronous reset mid-EXECUTE.
    cyc(0, 0, 1, 5'b00000, 0, "ar_halt");
    cyc(0, 0, 1, 5'b00001, 0, "ar_f");
    cyc(0, 0, 1, 5'b00010, 0, "ar_d");
    #1;
    check("ar_pre_phase", 32'(phase), 32'b00100);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_phase", 32'(phase), 32'd0);
    check("ar_stage_en", 32'(stage_en), 32'd0);
    check("ar_retire", 32'(retire), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_retire_cnt", 32'(retire_cnt), 32'd0);
    check("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 17 back-to-back instructions: 4-bit retire counter wraps to 1.
    cyc(0, 0, 1, 5'b00000, 0, "wr_halt");
    for (int n = 0; n < 17; n++) begin
      for (int k = 0; k < NP; k++) begin
        logic [NP-1:0] ph;
        ph = NP'(1 << k);
        cyc(0, 0, (n < 16) || (k < NP - 1), ph, k == NP - 1, "wrap");
      end
    end
    cyc(0, 0, 0, 5'b00000, 0, "wr_end");
`ifdef PHASE_PERF_CNT_EN
    exp_wrap = 4'd1;
`else
    exp_wrap = 4'd0;
`endif
    check("wrap_retire_cnt", 32'(retire_cnt), 32'(exp_wrap));
    check("wrap_stall_cnt", 32'(stall_cnt), 32'd0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
